bram_tdp_be_pipe: RTL and testbench
===================================

Name: bram_tdp_be_pipe

Overview:
Parametrised true-dual-port block RAM, single clock, successor to the fixed 512x16384 dual-port array.
Adds:
- per-byte write enables
- configurable read latency with a valid pipeline
- selectable read-during-write mode
- deterministic cross-port collision resolution with a flag
- optional post-reset clear sequencer

Serves as the local/accumulator memory bank behind the TCU's DRAM and array ports.

Parameters:
DATA_W, 512, word width in bits; must be a multiple of 8
ADDR_W, 14, address width; DEPTH = 2**ADDR_W
BE_W, DATA_W/8, byte-enable width (derived, not overridable)
RD_LATENCY, 1, cycles from accepted read to rdata; legal 1..3
RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
CLEAR_ON_RESET, 1, 1 = zero all DEPTH words after reset before accepting traffic

Ports:
clock  in  1  single clock; all logic on its rising edge
reset  in  1  synchronous, active-high
init_done  out  1  high when user ports are accepted
a_en  in  1  port A access request
a_we  in  BE_W  port A byte write mask; all-zero = read
a_addr  in  ADDR_W  port A address
a_wdata  in  DATA_W  port A write data
a_rdata  out  DATA_W  port A read data
a_rvalid  out  1  a_rdata valid this cycle
b_en, b_we, b_addr, b_wdata, b_rdata, b_rvalid  same as port A, for port B
collision  out  1  one-cycle pulse; previous cycle had a cross-port same-address conflict

Behaviour:
- Interface: one clock (clock); reset synchronous, active-high (reset).
- Reset values: a_rdata = b_rdata = 0, a_rvalid = b_rvalid = 0, collision = 0, init_done = 0. Memory contents are not reset directly.
- FSM states: CLEAR, READY. Reset forces CLEAR with clr_addr = 0 when CLEAR_ON_RESET = 1, otherwise READY.
- CLEAR state:
  - Each cycle writes all-zero to clr_addr through the port-A path, then increments clr_addr.
  - At clr_addr = DEPTH-1, writes the last word and goes to READY. init_done rises the next cycle, DEPTH+1 cycles after reset deasserts.
  - User en inputs are ignored; no writes, no rvalid.
  - Reset mid-clear restarts at clr_addr = 0.
- READY: init_done = 1. With CLEAR_ON_RESET = 0, init_done is 1 on the first cycle after reset deasserts.
- Access acceptance: x_en is accepted when init_done = 1, with no ready/backpressure. A read is a_en with a_we = 0. A write updates only bytes i where we[i] = 1.
- Read data and latency:
  - Every accepted access, including writes, returns data on x_rdata exactly RD_LATENCY cycles later, with x_rvalid high for that one cycle.
  - x_rdata holds its last value when x_rvalid = 0.
- Same-port read-during-write: RDW_MODE = 0 returns the pre-write word. RDW_MODE = 1 returns the merged word (new bytes where we = 1, old bytes elsewhere).
- Cross-port collision is defined as a_en & b_en & (a_addr == b_addr) & (|a_we | |b_we):
  - Write/write: bytes written by both ports take port A data; bytes written by one port take that port's data.
  - Read/write: the reading port gets the pre-write word, independent of RDW_MODE.
  - collision pulses high the cycle after the conflict. Read/read on the same address is not a collision.
- Reads are pipelined at full throughput: back-to-back reads every cycle, both ports concurrently.
- Reset during traffic: in-flight rvalid pipeline stages flush to 0, and no pending data is delivered.

Decomposition:
- Package bram_pkg holds:
  - RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1
  - FSM state type {CLEAR, READY}
  - function byte_merge(old, new, mask)
- Sub-module bram_rd_pipe, one instance per port:
  - RD_LATENCY-deep data/valid shift register with reset on the valid bits only
  - data stages enabled by the valid bit

Test Plan:
Bench uses DATA_W = 32, ADDR_W = 4 unless stated.
1. Reset, CLEAR_ON_RESET = 1 -> init_done low for 17 cycles after reset falls; then a read of every address returns 0x00000000; a_en during CLEAR produces no a_rvalid.
2. Byte masks: write 0xDEADBEEF to addr 3; write 0x11223344 with we = 4'b0101; read addr 3 -> 0xDE22BE44, with rvalid exactly RD_LATENCY cycles after en for RD_LATENCY = 1, 2, 3.
3. RDW: addr 5 holds 0xAAAAAAAA; same-port write 0x55555555 with we = 4'hF -> rdata 0xAAAAAAAA with RDW_MODE = 0, 0x55555555 with RDW_MODE = 1.
4. Cross-port write/write to addr 7: A writes 0x000000FF (we = 4'b0011), B writes 0xFFFF0000 (we = 4'b0110) -> collision pulse next cycle; addr 7 reads 0x00FF00FF over the previous 0x00000000.
5. Cross-port read/write to addr 2 (old 0x12345678), B writes 0xCAFEF00D -> A rdata 0x12345678, collision = 1; a subsequent read returns 0xCAFEF00D. Read/read on addr 2 -> collision = 0.
6. Streaming and reset: 16 back-to-back reads on both ports with RD_LATENCY = 3 -> 16 contiguous rvalid cycles per port, in order. Asserting reset mid-stream -> rvalid drops to 0 on the next edge, and CLEAR restarts at addr 0.

Source files
------------

// File: rtl/bram_pkg.sv
// bram_pkg: shared types, read-during-write codes and byte-merge helper for the dual-port RAM
package bram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest word the merge helper handles; callers cast to and from their own width
    localparam int MAX_W  = 4096;
    localparam int MAX_BE = MAX_W / 8;

    typedef enum logic {CLEAR, READY} state_t;

    function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w,
                                                    input logic [MAX_W-1:0] nw_w,
                                                    input logic [MAX_BE-1:0] mask);
        for (int i = 0; i < MAX_BE; i++)
            byte_merge[8*i +: 8] = mask[i] ? nw_w[8*i +: 8] : old_w[8*i +: 8];
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// bram_rd_pipe: LAT-deep read data/valid shift register; data stages only load behind a valid bit
module bram_rd_pipe #(
    parameter int W   = 512,
    parameter int LAT = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         v_i,
    input  logic [W-1:0] d_i,
    output logic         v_o,
    output logic [W-1:0] d_o
);

    logic         v_q [LAT];
    logic [W-1:0] d_q [LAT];

    for (genvar i = 0; i < LAT; i++) begin : g_st
        logic         vin;
        logic [W-1:0] din;
        if (i == 0) begin : g_head
            assign vin = v_i;
            assign din = d_i;
        end else begin : g_tail
            assign vin = v_q[i-1];
            assign din = d_q[i-1];
        end
        // Valid bits flush on reset so nothing in flight is delivered afterwards
        always_ff @(posedge clock)
            if (reset) v_q[i] <= 1'b0;
            else       v_q[i] <= vin;
        // Data advances only with a valid bit; the output stage alone clears on reset
        always_ff @(posedge clock)
            if (reset && i == LAT-1) d_q[i] <= '0;
            else if (vin)            d_q[i] <= din;
    end

    assign v_o = v_q[LAT-1];
    assign d_o = d_q[LAT-1];

endmodule

// File: rtl/bram_tdp_be_pipe.sv
// bram_tdp_be_pipe: true-dual-port byte-enabled RAM with pipelined reads, collision flag and clear-on-reset
module bram_tdp_be_pipe
    import bram_pkg::*;
#(
    parameter int DATA_W         = 512,
    parameter int ADDR_W         = 14,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int BE_W          = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_done,
    input  logic              a_en,
    input  logic [BE_W-1:0]   a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic [BE_W-1:0]   b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic              collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    function automatic logic [DATA_W-1:0] mrg(input logic [DATA_W-1:0] o,
                                              input logic [DATA_W-1:0] n,
                                              input logic [BE_W-1:0] m);
        mrg = DATA_W'(byte_merge(MAX_W'(o), MAX_W'(n), MAX_BE'(m)));
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic              init_q, coll_q;
    logic              acc, a_wr, b_wr, same;
    logic [DATA_W-1:0] a_old, b_old, a_new, b_new, a_rd, b_rd;

    assign acc   = init_q & ~reset;
    assign a_wr  = acc & a_en & |a_we;
    assign b_wr  = acc & b_en & |b_we;
    assign same  = a_addr == b_addr;
    assign a_old = mem[a_addr];
    assign b_old = mem[b_addr];
    // Port A merges over port B's result so shared bytes take A's data
    assign b_new = mrg(b_old, b_wdata, b_we);
    assign a_new = mrg(same && b_wr ? b_new : a_old, a_wdata, a_we);
    // A reader with no write of its own always sees the pre-write word
    assign a_rd  = RDW_MODE == RDW_WRITE_FIRST ? mrg(a_old, a_wdata, a_we) : a_old;
    assign b_rd  = RDW_MODE == RDW_WRITE_FIRST ? mrg(b_old, b_wdata, b_we) : b_old;

    // Clear sequencer next state: sweep every address once, then open the user ports
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        if (state_q == CLEAR) begin
            clr_d   = clr_q + 1'b1;
            state_d = &clr_q ? READY : CLEAR;
        end
    end

    // Control registers: FSM, clear pointer, registered init_done and collision pulse
    always_ff @(posedge clock)
        if (reset) begin
            state_q <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
            clr_q   <= '0;
            init_q  <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            init_q  <= state_q == READY;
            coll_q  <= acc & a_en & b_en & same & (|a_we | |b_we);
        end

    // Array writes: clear path during CLEAR, otherwise B then A so A wins a shared address
    always_ff @(posedge clock)
        if (state_q == CLEAR && !reset) mem[clr_q] <= '0;
        else begin
            if (b_wr) mem[b_addr] <= b_new;
            if (a_wr) mem[a_addr] <= a_new;
        end

    assign init_done = init_q;
    assign collision = coll_q;

    bram_rd_pipe #(.W(DATA_W), .LAT(RD_LATENCY)) u_pipe_a (
        .clock(clock), .reset(reset), .v_i(acc & a_en), .d_i(a_rd), .v_o(a_rvalid), .d_o(a_rdata)
    );

    bram_rd_pipe #(.W(DATA_W), .LAT(RD_LATENCY)) u_pipe_b (
        .clock(clock), .reset(reset), .v_i(acc & b_en), .d_i(b_rd), .v_o(b_rvalid), .d_o(b_rdata)
    );

endmodule

// File: tb/tb_bram_tdp_be_pipe.sv
// tb_bram_tdp_be_pipe: scoreboard bench over three RAM configurations sharing one stimulus stream
module tb_bram_tdp_be_pipe;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        a_en = 1'b0, b_en = 1'b0;
    logic [3:0]  a_we = '0, b_we = '0, a_addr = '0, b_addr = '0;
    logic [31:0] a_wd = '0, b_wd = '0;
    logic [31:0] rd [6];
    logic        rv [6];
    logic        coll [3];
    logic        idn [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bram_tdp_be_pipe #(
            .DATA_W(32), .ADDR_W(4), .RD_LATENCY(g + 1), .RDW_MODE(g % 2), .CLEAR_ON_RESET(1)
        ) u_dut (
            .clock(clk), .reset(rst), .init_done(idn[g]),
            .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wd),
            .a_rdata(rd[2*g]), .a_rvalid(rv[2*g]),
            .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wd),
            .b_rdata(rd[2*g+1]), .b_rvalid(rv[2*g+1]),
            .collision(coll[g])
        );
    end

    typedef struct {
        int          due;
        logic [31:0] d;
    } exp_t;

    exp_t        sb [6][$];
    bit          cexp [int];
    logic [31:0] mm [DEPTH];
    int          cyc = 0;
    int          rel = 1 << 30;
    int          n_chk = 0, n_fail = 0;
    logic        rst_e = 1'b1;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_e <= rst;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        mg = o;
        for (int i = 0; i < 4; i++) if (m[i]) mg[8*i +: 8] = n[8*i +: 8];
    endfunction

    // Monitor: compares every DUT output against the scoreboard on the falling edge
    always @(negedge clk) begin
        if (rst_e) begin
            for (int k = 0; k < 6; k++) begin
                chk("reset_rvalid", 32'(rv[k]), 0);
                chk("reset_rdata", rd[k], 0);
            end
            for (int d = 0; d < 3; d++) begin
                chk("reset_collision", 32'(coll[d]), 0);
                chk("reset_init_done", 32'(idn[d]), 0);
            end
        end else begin
            logic ce;
            ce = cexp.exists(cyc) ? cexp[cyc] : 1'b0;
            cexp.delete(cyc);
            for (int d = 0; d < 3; d++) begin
                chk("init_done", 32'(idn[d]), 32'(cyc >= rel + DEPTH + 1));
                chk("collision", 32'(coll[d]), 32'(ce));
            end
            for (int k = 0; k < 6; k++) begin
                if (rv[k]) begin
                    if (sb[k].size() == 0 || sb[k][0].due != cyc) chk("unexpected_rvalid", 1, 0);
                    else begin
                        chk($sformatf("rdata_%0d", k), rd[k], sb[k][0].d);
                        void'(sb[k].pop_front());
                    end
                end else if (sb[k].size() != 0 && sb[k][0].due <= cyc) begin
                    chk($sformatf("missing_rvalid_%0d", k), 0, 1);
                    void'(sb[k].pop_front());
                end
            end
        end
    end

    // One cycle of stimulus on both ports; the model predicts reads before applying writes
    task automatic acc(input logic ae, input logic [3:0] aw, input logic [3:0] aa, input logic [31:0] ad,
                       input logic be, input logic [3:0] bw, input logic [3:0] ba, input logic [31:0] bd);
        logic [31:0] oa, ob;
        exp_t e;
        @(posedge clk);
        #2;
        a_en = ae; a_we = aw; a_addr = aa; a_wd = ad;
        b_en = be; b_we = bw; b_addr = ba; b_wd = bd;
        if (!rst && cyc >= rel + DEPTH + 1) begin
            oa = mm[aa];
            ob = mm[ba];
            for (int d = 0; d < 3; d++) begin
                e.due = cyc + d + 1;
                if (ae) begin
                    e.d = (d % 2 == 1) ? mg(oa, ad, aw) : oa;
                    sb[2*d].push_back(e);
                end
                if (be) begin
                    e.d = (d % 2 == 1) ? mg(ob, bd, bw) : ob;
                    sb[2*d+1].push_back(e);
                end
            end
            if (ae && be && aa == ba && (aw != 0 || bw != 0)) cexp[cyc + 1] = 1'b1;
            if (be) mm[ba] = mg(mm[ba], bd, bw);
            if (ae) mm[aa] = mg(mm[aa], ad, aw);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) acc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        int ks[$];
        @(posedge clk);
        #2;
        rst = 1'b1;
        a_en = 1'b0; b_en = 1'b0; a_we = '0; b_we = '0;
        for (int k = 0; k < 6; k++)
            while (sb[k].size() != 0 && sb[k][$].due > cyc) void'(sb[k].pop_back());
        foreach (cexp[key]) if (key > cyc) ks.push_back(key);
        foreach (ks[j]) cexp.delete(ks[j]);
        repeat (n) @(posedge clk);
        #2;
        rst = 1'b0;
        rel = cyc;
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lows;
        logic [3:0] w;
        do_reset(3);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (idn[0]) break;
            lows++;
        end
        chk("init_low_cycles", lows, DEPTH + 1);
        for (int i = 0; i < 10; i++) acc(1, 4'hF, 4'(i), 32'hFFFF_FFFF, 1, 4'hF, 4'(i + 5), 32'h5A5A_5A5A);
        do_reset(2);
        idle(5);
        do_reset(2);
        for (int i = 0; i < 20; i++) acc(1, 0, 4'($urandom), 0, 1, 0, 4'($urandom), 0);
        for (int i = 0; i < DEPTH; i++) acc(1, 0, 4'(i), 0, 1, 0, 4'(DEPTH - 1 - i), 0);
        acc(1, 4'hF, 3, 32'hDEAD_BEEF, 0, 0, 0, 0);
        acc(1, 4'b0101, 3, 32'h1122_3344, 0, 0, 0, 0);
        acc(1, 0, 3, 0, 1, 0, 3, 0);
        acc(1, 4'hF, 5, 32'hAAAA_AAAA, 0, 0, 0, 0);
        acc(1, 4'hF, 5, 32'h5555_5555, 0, 0, 0, 0);
        acc(1, 0, 5, 0, 0, 0, 0, 0);
        acc(0, 0, 0, 0, 1, 4'hF, 7, 32'h0);
        acc(1, 4'b0011, 7, 32'h0000_00FF, 1, 4'b0110, 7, 32'hFFFF_0000);
        acc(1, 0, 7, 0, 1, 0, 7, 0);
        acc(1, 4'hF, 2, 32'h1234_5678, 0, 0, 0, 0);
        acc(1, 0, 2, 0, 1, 4'hF, 2, 32'hCAFE_F00D);
        acc(1, 0, 2, 0, 1, 0, 2, 0);
        idle(3);
        for (int i = 0; i < 300; i++) begin
            w = ($urandom % 2 != 0) ? 4'($urandom) : 4'h0;
            acc($urandom % 4 != 0, w, 4'($urandom % (i < 150 ? 4 : 16)), $urandom,
                $urandom % 4 != 0, 4'(($urandom % 2 != 0) ? $urandom : 0), 4'($urandom % (i < 150 ? 4 : 16)), $urandom);
        end
        for (int i = 0; i < 16; i++) acc(1, 0, 4'(i), 0, 1, 0, 4'(15 - i), 0);
        for (int i = 0; i < 8; i++) acc(1, 0, 4'(i), 0, 1, 0, 4'(i + 8), 0);
        do_reset(2);
        for (int i = 0; i < DEPTH + 2; i++) acc(1, 0, 4'(i), 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) acc(1, 0, 4'(i), 0, 1, 0, 4'(i), 0);
        idle(6);
        for (int k = 0; k < 6; k++) chk("drain", sb[k].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
